// File: rtl/key_pkg.sv
// key_pkg: shared encodings and defaults for the push-button debouncer
package key_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILTER_DN = 2'd1,
    DOWN      = 2'd2,
    FILTER_UP = 2'd3
  } key_state_e;

  localparam int   CNT_MAX_DEF    = 1_000_000;
  localparam logic KEY_ACTIVE_DEF = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs with a chosen reset value
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // first flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: debounced level plus single-cycle press/release pulses for one button
module key_debounce
  import key_pkg::*;
#(
  parameter int   CNT_MAX    = CNT_MAX_DEF,
  parameter logic KEY_ACTIVE = KEY_ACTIVE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_pulse,
  output logic key_release,
  output logic key_state
);

  localparam int            CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic          s;
  logic          p;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          release_q, release_d;
  logic          level_q, level_d;

  sync_2ff #(
    .W       (1),
    .RST_VAL (~KEY_ACTIVE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (key_in),
    .q_o (s)
  );

  assign p = (s == KEY_ACTIVE);

  // state, counter and output registers; reset drops any pulse in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
      level_q   <= level_d;
    end
  end

  // filter: any break in stability restarts the count from the stable side
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    release_d = 1'b0;
    level_d   = level_q;
    case (state_q)
      IDLE: if (p) begin
        state_d = FILTER_DN;
        cnt_d   = '0;
      end
      FILTER_DN: begin
        if (!p) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          pulse_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DOWN: if (!p) begin
        state_d = FILTER_UP;
        cnt_d   = '0;
      end
      FILTER_UP: begin
        if (p) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_pulse   = pulse_q;
  assign key_release = release_q;
  assign key_state   = level_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scoreboard bench for key_debounce with CNT_MAX=8, active-low key
module tb_key_debounce;

  localparam int LAT = 11;

  typedef struct {
    int         at;
    logic [1:0] kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b1;
  logic key_pulse, key_release, key_state;
  logic [1:0] step;
  int edge_n = 0;
  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];

  key_debounce #(.CNT_MAX(8), .KEY_ACTIVE(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_pulse   (key_pulse),
    .key_release (key_release),
    .key_state   (key_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // downstream three-state stepping FSM driven by key_pulse as its enable
  always @(posedge clk or posedge rst) begin
    if (rst) step <= 2'd0;
    else if (key_pulse) step <= (step == 2'd2) ? 2'd0 : step + 2'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind);
    ev_t e;
    e.at   = edge_n + LAT;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // every observed pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && (key_pulse || key_release)) begin
      ev_t e;
      chk("pulse_exclusive", {31'd0, key_pulse && key_release}, 32'd0);
      chk("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_kind", {30'd0, key_pulse, key_release}, {30'd0, e.kind});
        chk("sb_edge", edge_n, e.at);
      end
    end
  end

  initial begin
    int m;
    wait_n(3);
    chk("rst_pulse", {31'd0, key_pulse}, 32'd0);
    chk("rst_release", {31'd0, key_release}, 32'd0);
    chk("rst_state", {31'd0, key_state}, 32'd0);
    rst = 1'b0;
    wait_n(5);
    // clean press held for 100 cycles
    m = edge_n;
    key_in = 1'b0;
    expect_ev(2'b10);
    wait_n(10);
    chk("press_state_before", {31'd0, key_state}, 32'd0);
    wait_n(1);
    chk("press_state_after", {31'd0, key_state}, 32'd1);
    chk("press_edge", edge_n, m + LAT);
    wait_n(100);
    chk("held_state", {31'd0, key_state}, 32'd1);
    chk("step_after_p1", {30'd0, step}, 32'd1);
    // clean release
    key_in = 1'b1;
    expect_ev(2'b01);
    wait_n(10);
    chk("rel_state_before", {31'd0, key_state}, 32'd1);
    wait_n(1);
    chk("rel_state_after", {31'd0, key_state}, 32'd0);
    wait_n(20);
    // bounce every 3 cycles for 30 cycles, then stable press
    for (int i = 0; i < 10; i++) begin
      key_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_n(3);
    end
    chk("bounce_state", {31'd0, key_state}, 32'd0);
    key_in = 1'b0;
    expect_ev(2'b10);
    wait_n(30);
    chk("step_after_p2", {30'd0, step}, 32'd2);
    // short release glitch while down
    key_in = 1'b1;
    wait_n(5);
    key_in = 1'b0;
    wait_n(30);
    chk("glitch_state", {31'd0, key_state}, 32'd1);
    chk("glitch_step", {30'd0, step}, 32'd2);
    key_in = 1'b1;
    expect_ev(2'b01);
    wait_n(20);
    // third press wraps the stepping FSM back to IDLE
    key_in = 1'b0;
    expect_ev(2'b10);
    wait_n(20);
    chk("step_after_p3", {30'd0, step}, 32'd0);
    key_in = 1'b1;
    expect_ev(2'b01);
    wait_n(20);
    // reset in FILTER_DN with cnt=5, button kept pressed
    key_in = 1'b0;
    wait_n(8);
    rst = 1'b1;
    #1;
    chk("rst_mid_pulse", {31'd0, key_pulse}, 32'd0);
    chk("rst_mid_release", {31'd0, key_release}, 32'd0);
    chk("rst_mid_state", {31'd0, key_state}, 32'd0);
    wait_n(1);
    rst = 1'b0;
    expect_ev(2'b10);
    wait_n(20);
    chk("refilter_state", {31'd0, key_state}, 32'd1);
    chk("refilter_step", {30'd0, step}, 32'd1);
    key_in = 1'b1;
    expect_ev(2'b01);
    wait_n(20);
    // reset lands while the press pulse is high
    m = edge_n;
    key_in = 1'b0;
    wait_n(10);
    @(posedge clk);
    #1;
    chk("inflight_pulse_high", {31'd0, key_pulse}, 32'd1);
    rst = 1'b1;
    #1;
    chk("inflight_pulse_dropped", {31'd0, key_pulse}, 32'd0);
    chk("inflight_state_cleared", {31'd0, key_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_ev(2'b10);
    wait_n(20);
    chk("fresh_state", {31'd0, key_state}, 32'd1);
    chk("fresh_step", {30'd0, step}, 32'd1);
    key_in = 1'b1;
    expect_ev(2'b01);
    wait_n(30);
    chk("sb_drained", exp_q.size(), 32'd0);
    chk("final_state", {31'd0, key_state}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
